// File: rtl/pio_instr_mem_pkg.sv
// Shared types and widths for the PIO instruction memory and its byte-stream loader.
package pio_pkg;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    GET_LO,
    GET_HI
  } loader_state_t;
endpackage

// File: rtl/pio_instr_mem_if.sv
// Host-side bus of the PIO instruction memory: direct writes, stream loader and read ports.
interface pio_instr_mem_if #(
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 4
);
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [15:0]               wr_data;
  logic                      load_start;
  logic [ADDR_W-1:0]         load_base;
  logic [ADDR_W:0]           load_len;
  logic                      load_valid;
  logic                      load_ready;
  logic [7:0]                load_byte;
  logic                      load_busy;
  logic                      load_done;
  logic [NUM_PORTS-1:0]      rd_en;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS*16-1:0]   rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, load_start, load_base, load_len,
           load_valid, load_byte, rd_en, rd_addr,
    input  load_ready, load_busy, load_done, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, load_start, load_base, load_len,
           load_valid, load_byte, rd_en, rd_addr,
    output load_ready, load_busy, load_done, rd_data
  );
endinterface

// File: rtl/pio_instr_loader.sv
// Byte-stream loader: pairs little-endian bytes into words and writes them at an auto-incrementing pointer.
//
// state  | meaning
// IDLE   | no load in progress, stream not accepted
// GET_LO | waiting for the low byte of the next word
// GET_HI | low byte latched, waiting for the high byte (stalls while a direct write is active)
module pio_instr_loader
  import pio_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [ADDR_W:0]    load_len,
  input  logic               load_valid,
  input  logic [BYTE_W-1:0]  load_byte,
  input  logic               wr_en,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata
);
  loader_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [BYTE_W-1:0] lo_q;
  logic              hs;

  // A restart wins over any byte offered in the same cycle.
  always_comb begin
    load_ready = 1'b0;
    if (!load_start) begin
      load_ready = (state == GET_LO) || ((state == GET_HI) && !wr_en);
    end
  end

  assign hs        = load_valid && load_ready;
  assign load_busy = (state != IDLE);
  assign mem_we    = hs && (state == GET_HI);
  assign mem_addr  = ptr;
  assign mem_wdata = {load_byte, lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      lo_q      <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        lo_q <= '0;
        if (load_len == '0) begin
          state     <= IDLE;
          remaining <= '0;
          load_done <= 1'b1;
        end else begin
          ptr       <= load_base;
          remaining <= load_len;
          state     <= GET_LO;
        end
      end else begin
        case (state)
          GET_LO: begin
            if (hs) begin
              lo_q  <= load_byte;
              state <= GET_HI;
            end
          end
          GET_HI: begin
            if (hs) begin
              ptr       <= ptr + ADDR_W'(1);
              remaining <= remaining - (ADDR_W+1)'(1);
              if (remaining == (ADDR_W+1)'(1)) begin
                state     <= IDLE;
                load_done <= 1'b1;
              end else begin
                state <= GET_LO;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/pio_instr_mem.sv
// PIO instruction store: direct/stream-loaded word array with NUM_PORTS registered read ports.
module pio_instr_mem
  import pio_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 4
) (
  input logic            clk,
  input logic            rst_n,
  pio_instr_mem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rd_q [NUM_PORTS];
  logic               ld_we;
  logic [ADDR_W-1:0]  ld_addr;
  logic [INSTR_W-1:0] ld_wdata;

  pio_instr_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (bus.load_start),
    .load_base  (bus.load_base),
    .load_len   (bus.load_len),
    .load_valid (bus.load_valid),
    .load_byte  (bus.load_byte),
    .wr_en      (bus.wr_en),
    .load_ready (bus.load_ready),
    .load_busy  (bus.load_busy),
    .load_done  (bus.load_done),
    .mem_we     (ld_we),
    .mem_addr   (ld_addr),
    .mem_wdata  (ld_wdata)
  );

  // Storage is cleared by reset, so it lives in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_wdata;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q[p] <= '0;
      end else if (bus.rd_en[p]) begin
        rd_q[p] <= mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) bus.rd_data[p*INSTR_W +: INSTR_W] = rd_q[p];
  end
endmodule

// File: tb/tb_pio_instr_mem.sv
// Directed bench for pio_instr_mem: reset, stream loads with wrap/stall/abort, direct writes, reads.
module tb_pio_instr_mem;
  localparam int ADDR_W = 5;
  localparam int NP     = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  pio_instr_mem_if #(.ADDR_W(ADDR_W), .NUM_PORTS(NP)) bus ();

  pio_instr_mem #(.ADDR_W(ADDR_W), .NUM_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    bus.load_len   = len;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    #1;
    while (!bus.load_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!bus.load_ready) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic read_all(input string tag, input logic [ADDR_W-1:0] a, input logic [15:0] exp);
    bus.rd_en = '1;
    for (int p = 0; p < NP; p++) bus.rd_addr[p*ADDR_W +: ADDR_W] = a;
    tick();
    bus.rd_en = '0;
    for (int p = 0; p < NP; p++) chk(tag, 32'(bus.rd_data[p*16 +: 16]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    #12;
    chk("rst_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_busy",  32'(bus.load_busy),  32'd0);
    chk("rst_done",  32'(bus.load_done),  32'd0);
    chk("rst_rdata", 32'(bus.rd_data[31:0]), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) read_all("rst_mem", ADDR_W'(a), 16'h0000);
    chk("idle_ready", 32'(bus.load_ready), 32'd0);

    // Wrapping load: 30, 31, 0
    start_load(5'd30, 6'd3);
    chk("ld_busy", 32'(bus.load_busy), 32'd1);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    chk("ld_done_early", 32'(bus.load_done), 32'd0);
    send_byte(8'h66);
    chk("ld_done",     32'(bus.load_done), 32'd1);
    chk("ld_busy_end", 32'(bus.load_busy), 32'd0);
    tick();
    chk("ld_done_1cyc", 32'(bus.load_done), 32'd0);
    read_all("wrap_m30", 5'd30, 16'h2211);
    read_all("wrap_m31", 5'd31, 16'h4433);
    read_all("wrap_m0",  5'd0,  16'h6655);

    // Direct write stalls the high byte
    start_load(5'd10, 6'd1);
    send_byte(8'h77);
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h88;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 5'd5;
    bus.wr_data    = 16'hBEEF;
    #1;
    chk("stall_ready0", 32'(bus.load_ready), 32'd0);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("stall_ready1", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
    chk("stall_done", 32'(bus.load_done), 32'd1);
    read_all("stall_m5",  5'd5,  16'hBEEF);
    read_all("stall_m10", 5'd10, 16'h8877);

    // Abort after low byte; restart byte offered in same cycle is not consumed
    start_load(5'd2, 6'd1);
    send_byte(8'hAA);
    bus.load_start = 1'b1;
    bus.load_base  = 5'd2;
    bus.load_len   = 6'd1;
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h55;
    #1;
    chk("abort_ready0", 32'(bus.load_ready), 32'd0);
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("abort_nodone", 32'(bus.load_done), 32'd0);
    chk("abort_busy",   32'(bus.load_busy), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("abort_done", 32'(bus.load_done), 32'd1);
    tick();
    chk("abort_done_once", 32'(bus.load_done), 32'd0);
    read_all("abort_m2", 5'd2, 16'h0201);

    // Read-during-write is read-first on every port
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 16'h1234;
    read_all("rdw_old", 5'd7, 16'h0000);
    bus.wr_en = 1'b0;
    read_all("rdw_new", 5'd7, 16'h1234);
    for (int p = 0; p < NP; p++) bus.rd_addr[p*ADDR_W +: ADDR_W] = 5'd30;
    tick();
    chk("rd_hold", 32'(bus.rd_data[16 +: 16]), 32'h1234);

    // Zero-length load
    start_load(5'd9, 6'd0);
    chk("zero_busy", 32'(bus.load_busy), 32'd0);
    chk("zero_done", 32'(bus.load_done), 32'd1);
    tick();
    chk("zero_done_once", 32'(bus.load_done), 32'd0);

    // Asynchronous reset mid-load
    start_load(5'd0, 6'd4);
    send_byte(8'h12);
    chk("mid_busy", 32'(bus.load_busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.load_busy),  32'd0);
    chk("arst_ready", 32'(bus.load_ready), 32'd0);
    chk("arst_done",  32'(bus.load_done),  32'd0);
    for (int p = 0; p < NP; p++) chk("arst_rdata", 32'(bus.rd_data[p*16 +: 16]), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    read_all("arst_m7",  5'd7,  16'h0000);
    read_all("arst_m30", 5'd30, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
